instruction_cache_refill: RTL and testbench

Miss-service controller for the instruction cache: the memory-side counterpart to the fetch stage's cache miss outputs. When the cache reports a miss, it holds the fetch stage stalled and requests the missing 4-word line from main memory one word at a time. Each returned word is written into the cache through its fill port. It sits between the fetch stage's cache (miss and tag out; stall, address, data and write enable in) and the main-memory read port.

---
 rtl/instruction_cache_refill_pkg.sv | 29 ++
 rtl/instruction_cache_refill_if.sv | 30 +++
 rtl/instruction_cache_refill.sv | 160 ++++++++++++++++
 tb/tb_instruction_cache_refill.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_refill_pkg.sv
// Shared types for the instruction-cache refill controller.
// Contents:
//   CacheWrControl  - cache fill-port write command.
//   RefillState     - refill FSM states.
//   CACHE_LINE_WORDS - words per cache line (fixed at 4).
//   line_word_addr  - builds a word-aligned address from a line base and word index.
package instruction_cache_refill_pkg;

  typedef enum logic [1:0] {
    CACHE_NO_WR = 2'b00,
    CACHE_W_WR  = 2'b01
  } CacheWrControl;

  typedef enum logic [2:0] {
    REFILL_IDLE  = 3'd0,
    REFILL_REQ   = 3'd1,
    REFILL_WAIT  = 3'd2,
    REFILL_WRITE = 3'd3,
    REFILL_DONE  = 3'd4
  } RefillState;

  localparam int CACHE_LINE_WORDS = 4;

  // Line base keeps bits [31:4]; the word index selects bits [3:2]; bits [1:0] are always zero.
  function automatic logic [31:0] line_word_addr(input logic [31:0] base, input logic [1:0] idx);
    return {base[31:4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_cache_refill_if.sv
// Main-memory read port used by the instruction-cache refill controller.
// Signals:
//   mem_rd_req   - read request valid (master -> slave)
//   mem_rd_addr  - word address of the request (master -> slave)
//   mem_rd_ready - memory accepts the request (slave -> master)
//   mem_rd_valid - read data valid (slave -> master)
//   mem_rd_data  - read data (slave -> master)
interface instruction_cache_refill_if;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ready,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ready,
    output mem_rd_valid,
    output mem_rd_data
  );
endinterface

// File: rtl/instruction_cache_refill.sv
// Instruction-cache miss service: on a miss, stalls fetch and refills the
// 4-word line from main memory one word at a time through the cache fill port.
// Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   -> fill starts at pc[3:2] and wraps (e.g. 2,3,0,1)
//   undefined -> fill always runs 0,1,2,3
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   pc                         - fetch address (line index and critical word)
//   instruction_cache_miss     - nonzero = miss on current pc
//   instruction_cache_tag      - tag of the missing line
//   instruction_cache_stall    - holds fetch while a refill is pending
//   instruction_cache_addr     - fill address
//   instruction_cache_wr_data  - fill data
//   instruction_cache_wr_en    - CACHE_W_WR during a fill write
//   mem                        - main-memory read port (master side)
//   refill_count               - number of completed refills (wraps)
module instruction_cache_refill
  import instruction_cache_refill_pkg::*;
#(
  parameter  int INST_MEM_CACHE_SIZE = 1024,
  localparam int INDEX_W = $clog2(INST_MEM_CACHE_SIZE / 16),
  localparam int TAG_W   = 28 - INDEX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  input  logic [3:0]          instruction_cache_miss,
  input  logic [TAG_W-1:0]    instruction_cache_tag,
  output logic                instruction_cache_stall,
  output logic [31:0]         instruction_cache_addr,
  output logic [31:0]         instruction_cache_wr_data,
  output CacheWrControl       instruction_cache_wr_en,
  instruction_cache_refill_if.master mem,
  output logic [31:0]         refill_count
);

  localparam int LINE_WORDS = CACHE_LINE_WORDS;
  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  RefillState    state_r, state_nxt;
  logic [31:0]   line_base_r, line_base_nxt;
  logic [1:0]    word_idx_r, word_idx_nxt;
  logic [1:0]    word_cnt_r, word_cnt_nxt;
  logic [31:0]   wr_data_nxt;
  logic [31:0]   addr_nxt;
  logic [1:0]    start_word;
  logic          miss_s;

  logic          mem_rd_req_r;
  logic [31:0]   mem_rd_addr_r;
  logic [31:0]   cache_addr_r;
  logic [31:0]   cache_wr_data_r;
  CacheWrControl cache_wr_en_r;
  logic [31:0]   refill_count_r;
  logic          unused_pc_bits;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_word     = pc[3:2];
  assign unused_pc_bits = ^{pc[31:INDEX_W+4], pc[1:0]};
`else
  assign start_word     = 2'd0;
  assign unused_pc_bits = ^{pc[31:INDEX_W+4], pc[3:0]};
`endif

  assign miss_s = (instruction_cache_miss != 4'b0000);

  // Next-state, line latch, word sequencing and fill-data capture.
  always_comb begin
    state_nxt     = state_r;
    line_base_nxt = line_base_r;
    word_idx_nxt  = word_idx_r;
    word_cnt_nxt  = word_cnt_r;
    wr_data_nxt   = 32'd0;
    case (state_r)
      REFILL_IDLE: begin
        if (miss_s) begin
          line_base_nxt = {instruction_cache_tag, pc[INDEX_W+3:4], 4'b0000};
          word_idx_nxt  = start_word;
          word_cnt_nxt  = 2'd0;
          state_nxt     = REFILL_REQ;
        end else begin
          state_nxt = REFILL_IDLE;
        end
      end
      REFILL_REQ: begin
        if (mem.mem_rd_ready) begin
          state_nxt = REFILL_WAIT;
        end else begin
          state_nxt = REFILL_REQ;
        end
      end
      REFILL_WAIT: begin
        if (mem.mem_rd_valid) begin
          wr_data_nxt = mem.mem_rd_data;
          state_nxt   = REFILL_WRITE;
        end else begin
          state_nxt = REFILL_WAIT;
        end
      end
      REFILL_WRITE: begin
        if (word_cnt_r == LAST_WORD) begin
          state_nxt = REFILL_DONE;
        end else begin
          word_cnt_nxt = word_cnt_r + 2'd1;
          word_idx_nxt = word_idx_r + 2'd1;  // 2-bit wrap gives 3 -> 0
          state_nxt    = REFILL_REQ;
        end
      end
      REFILL_DONE: begin
        state_nxt = REFILL_IDLE;
      end
      default: begin
        state_nxt = REFILL_IDLE;
      end
    endcase
    addr_nxt = line_word_addr(line_base_nxt, word_idx_nxt);
  end

  // State, sequencing registers and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= REFILL_IDLE;
      line_base_r     <= 32'd0;
      word_idx_r      <= 2'd0;
      word_cnt_r      <= 2'd0;
      mem_rd_req_r    <= 1'b0;
      mem_rd_addr_r   <= 32'd0;
      cache_addr_r    <= 32'd0;
      cache_wr_data_r <= 32'd0;
      cache_wr_en_r   <= CACHE_NO_WR;
      refill_count_r  <= 32'd0;
    end else begin
      state_r         <= state_nxt;
      line_base_r     <= line_base_nxt;
      word_idx_r      <= word_idx_nxt;
      word_cnt_r      <= word_cnt_nxt;
      mem_rd_req_r    <= (state_nxt == REFILL_REQ);
      mem_rd_addr_r   <= (state_nxt == REFILL_REQ) ? addr_nxt : 32'd0;
      cache_addr_r    <= (state_nxt == REFILL_WRITE) ? addr_nxt : 32'd0;
      cache_wr_data_r <= (state_nxt == REFILL_WRITE) ? wr_data_nxt : 32'd0;
      cache_wr_en_r   <= (state_nxt == REFILL_WRITE) ? CACHE_W_WR : CACHE_NO_WR;
      if (state_r == REFILL_DONE) begin
        refill_count_r <= refill_count_r + 32'd1;
      end else begin
        refill_count_r <= refill_count_r;
      end
    end
  end

  // Stall must rise in the miss cycle itself, so it is combinational; reset
  // gating keeps it low while reset is held even if the miss input is still up.
  assign instruction_cache_stall   = ~reset & ((state_r != REFILL_IDLE) | miss_s);
  assign instruction_cache_addr    = cache_addr_r;
  assign instruction_cache_wr_data = cache_wr_data_r;
  assign instruction_cache_wr_en   = cache_wr_en_r;
  assign mem.mem_rd_req            = mem_rd_req_r;
  assign mem.mem_rd_addr           = mem_rd_addr_r;
  assign refill_count              = refill_count_r;

endmodule

// File: tb/tb_instruction_cache_refill.sv
// Self-checking bench for instruction_cache_refill: a transaction-level model
// (queue of pending line-word addresses plus a few phase flags) predicts every
// output on every falling edge; directed scenarios add literal expectations.
module tb_instruction_cache_refill;
  import instruction_cache_refill_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc;
  logic [3:0]    miss;
  logic [21:0]   tag;
  logic          stall;
  logic [31:0]   c_addr;
  logic [31:0]   c_data;
  CacheWrControl c_wr_en;
  logic [31:0]   refill_count;

  instruction_cache_refill_if mem_if ();

  instruction_cache_refill dut (
    .clk                       (clk),
    .reset                     (reset),
    .pc                        (pc),
    .instruction_cache_miss    (miss),
    .instruction_cache_tag     (tag),
    .instruction_cache_stall   (stall),
    .instruction_cache_addr    (c_addr),
    .instruction_cache_wr_data (c_data),
    .instruction_cache_wr_en   (c_wr_en),
    .mem                       (mem_if.master),
    .refill_count              (refill_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          rdy_delay = 0;
  bit          rand_mode = 1'b0;
  int          hold = 0;
  logic [31:0] salt = 32'd0;

  initial begin
    bit acc;
    logic [31:0] acc_a;
    mem_if.mem_rd_ready = 1'b0;
    mem_if.mem_rd_valid = 1'b0;
    mem_if.mem_rd_data  = 32'd0;
    forever begin
      @(negedge clk);
      acc   = mem_if.mem_rd_req && mem_if.mem_rd_ready && !reset;
      acc_a = mem_if.mem_rd_addr;
      @(posedge clk);
      #1;
      if (rand_mode) begin
        mem_if.mem_rd_ready = 1'($urandom_range(0, 1));
        mem_if.mem_rd_valid = 1'($urandom_range(0, 1));
        mem_if.mem_rd_data  = $urandom;
      end else begin
        mem_if.mem_rd_valid = acc;
        mem_if.mem_rd_data  = acc ? ((acc_a ^ 32'hC0DE_0000) + salt) : 32'd0;
        if (acc) salt = salt + 32'h0000_0101;
        if (mem_if.mem_rd_req) begin
          mem_if.mem_rd_ready = (hold >= rdy_delay);
          hold++;
        end else begin
          mem_if.mem_rd_ready = 1'b0;
          hold = 0;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];
  bit          m_req, m_wait, m_write, m_done;
  logic [31:0] m_cur, m_wa, m_wd;
  logic [31:0] m_count = 32'd0;

  initial begin
    logic [31:0] base;
    int start;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_req = 0; m_wait = 0; m_write = 0; m_done = 0;
        m_count = 32'd0;
      end else if (m_done) begin
        m_done  = 0;
        m_count = m_count + 32'd1;
      end else if (m_write) begin
        m_write = 0;
        if (m_q.size() == 0) m_done = 1;
        else m_req = 1;
      end else if (m_wait) begin
        if (mem_if.mem_rd_valid) begin
          m_wait = 0; m_write = 1;
          m_wa = m_cur; m_wd = mem_if.mem_rd_data;
        end
      end else if (m_req) begin
        if (mem_if.mem_rd_ready) begin
          m_cur = m_q.pop_front();
          m_req = 0; m_wait = 1;
        end
      end else if (miss != 4'b0000) begin
        base = ({10'd0, tag} << 10) | (pc & 32'h0000_03F0);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        start = int'((pc >> 2) & 32'd3);
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) m_q.push_back(base + 32'(((start + k) % 4) * 4));
        m_req = 1;
      end
    end
  end

  // ---------------- compare process + monitor ----------------
  logic [31:0] rd_log[$];
  int wr_count = 0;
  int req_cycles = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_if.mem_rd_req), 32'd0);
        chk("rst_rd_addr", mem_if.mem_rd_addr, 32'd0);
        chk("rst_wr_en", 32'(c_wr_en), 32'(CACHE_NO_WR));
        chk("rst_c_addr", c_addr, 32'd0);
        chk("rst_c_data", c_data, 32'd0);
        chk("rst_count", refill_count, 32'd0);
      end else begin
        chk("stall", 32'(stall), 32'(m_req | m_wait | m_write | m_done | (miss != 4'b0000)));
        chk("rd_req", 32'(mem_if.mem_rd_req), 32'(m_req));
        chk("rd_addr", mem_if.mem_rd_addr, m_req ? m_q[0] : 32'd0);
        chk("wr_en", 32'(c_wr_en), m_write ? 32'(CACHE_W_WR) : 32'(CACHE_NO_WR));
        chk("c_addr", c_addr, m_write ? m_wa : 32'd0);
        chk("c_data", c_data, m_write ? m_wd : 32'd0);
        chk("count", refill_count, m_count);
        if (mem_if.mem_rd_req && mem_if.mem_rd_ready) rd_log.push_back(mem_if.mem_rd_addr);
        if (c_wr_en == CACHE_W_WR) wr_count++;
        if (mem_if.mem_rd_req) req_cycles++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int scnt;
    logic [31:0] exp_rd[4];
    reset = 1'b1; pc = 32'd0; miss = 4'd0; tag = 22'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset while waiting for the third word's data.
    pc = 32'h0000_0048; tag = 22'h5;
    miss = 4'b0001;          // cycle 0
    tick(); miss = 4'd0;     // cycle 1
    repeat (7) tick();       // cycle 8: WAIT of third word
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_req", 32'(mem_if.mem_rd_req), 32'd0);
    chk("midrst_wr_en", 32'(c_wr_en), 32'(CACHE_NO_WR));
    tick(); tick();
    reset = 1'b0;
    wr_count = 0;
    tick();
    mem_if.mem_rd_valid = 1'b1;   // stale valid in IDLE
    mem_if.mem_rd_data  = 32'hBAD0_BAD0;
    repeat (3) tick();
    chk("stale_wr_count", 32'(wr_count), 32'd0);
    chk("stale_count", refill_count, 32'd0);

    // Basic refill, 1-cycle memory.
    pc = 32'h0000_0048; tag = 22'h0;
    rd_log.delete(); wr_count = 0; scnt = 0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    exp_rd = '{32'h48, 32'h4C, 32'h40, 32'h44};
`else
    exp_rd = '{32'h40, 32'h44, 32'h48, 32'h4C};
`endif
    miss = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) scnt++;
      tick();
      miss = 4'd0;
    end
    chk("basic_stall_cycles", 32'(scnt), 32'd14);
    chk("basic_nreads", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) chk("basic_rd_addr", rd_log[i], exp_rd[i]);
    end
    chk("basic_nwrites", 32'(wr_count), 32'd4);
    chk("basic_count", refill_count, 32'd1);

    // Ready held low for 5 REQ cycles, valid pulsed during REQ.
    rdy_delay = 5;
    pc = 32'h0000_0100; tag = 22'h3;
    wr_count = 0;
    miss = 4'b1000;
    tick(); miss = 4'd0;     // cycle 1, REQ
    mem_if.mem_rd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(mem_if.mem_rd_req), 32'd1);
      chk("hold_ready", 32'(mem_if.mem_rd_ready), 32'd0);
      chk("hold_addr", mem_if.mem_rd_addr, 32'h0000_0D00);
      chk("hold_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("hold_no_write", 32'(wr_count), 32'd0);
    scnt = 0;
    while (stall && scnt < 200) begin tick(); scnt++; end
    chk("hold_finished", 32'(stall), 32'd0);
    chk("hold_count", refill_count, 32'd2);
    rdy_delay = 0;

    // Valid pulse in IDLE.
    wr_count = 0;
    mem_if.mem_rd_valid = 1'b1;
    tick(); tick();
    chk("idle_valid_req", 32'(mem_if.mem_rd_req), 32'd0);
    chk("idle_valid_wr", 32'(wr_count), 32'd0);

    // Back-to-back misses, tags 1 then 2.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    rd_log.delete(); scnt = 0;
    pc = 32'h0000_0048; tag = 22'h1;
    miss = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) scnt++;
      tick();
      if (i + 1 == 1)  tag = 22'h2;
      if (i + 1 == 15) miss = 4'd0;
    end
    chk("b2b_stall_cycles", 32'(scnt), 32'd28);
    chk("b2b_nreads", 32'(rd_log.size()), 32'd8);
    if (rd_log.size() == 8) begin
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      chk("b2b_first_base", rd_log[0], 32'h0000_0448);
      chk("b2b_second_base", rd_log[4], 32'h0000_0848);
`else
      chk("b2b_first_base", rd_log[0], 32'h0000_0440);
      chk("b2b_second_base", rd_log[4], 32'h0000_0840);
`endif
    end
    chk("b2b_count", refill_count, 32'd2);

    // No miss, random memory activity.
    rand_mode = 1'b1; req_cycles = 0; wr_count = 0; scnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) scnt++;
      tick();
    end
    rand_mode = 1'b0;
    chk("quiet_req_cycles", 32'(req_cycles), 32'd0);
    chk("quiet_stall_cycles", 32'(scnt), 32'd0);
    chk("quiet_writes", 32'(wr_count), 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
